// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative multiply/divide unit in X.
// Latches operands, pulses start, stalls until ready/timeout, emits one result.
//
// Ports:
//   clock, reset                : clock; synchronous active-low reset
//   isMul_x, isDiv_x, rd_x      : mul/div instruction and its rd in X
//   operand_a, operand_b        : bypassed operands in X
//   md_result, md_exception,
//   md_resultRDY                : unit result, exception flag, result valid
//   ctrl_MULT, ctrl_DIV         : one-cycle start pulses to the unit
//   md_operandA, md_operandB    : operands latched at detect
//   isStillMultDiv              : stall for PC, F/D and D/X
//   result_valid, result_out,
//   result_reg, result_exception: one-cycle completion to the X/M latch
//   busy_cycles                 : BUSY cycles elapsed for the current op
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT      = 40,
    parameter logic [4:0]  RSTATUS_REG  = 5'd30,
    parameter logic [31:0] MUL_EXC_CODE = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE = 32'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        isMul_x,
    input  logic        isDiv_x,
    input  logic [4:0]  rd_x,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        isStillMultDiv,
    output logic        result_valid,
    output logic [31:0] result_out,
    output logic [4:0]  result_reg,
    output logic        result_exception,
    output logic [5:0]  busy_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_mul_q, is_mul_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        mult_q, mult_d;
    logic        div_q, div_d;
    logic [5:0]  busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  reg_q, reg_d;
    logic        exc_q, exc_d;
    logic        op_x;
    logic [31:0] exc_code;

    assign op_x     = isMul_x | isDiv_x;
    assign exc_code = is_mul_q ? MUL_EXC_CODE : DIV_EXC_CODE;

    always_comb begin
        state_d  = state_q;
        is_mul_d = is_mul_q;
        rd_d     = rd_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        mult_d   = 1'b0;
        div_d    = 1'b0;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        res_d    = res_q;
        reg_d    = reg_q;
        exc_d    = exc_q;
        unique case (state_q)
            S_IDLE: begin
                if (op_x) begin
                    // mul wins when both decode bits are set
                    state_d  = S_START;
                    is_mul_d = isMul_x;
                    rd_d     = rd_x;
                    opa_d    = operand_a;
                    opb_d    = operand_b;
                    mult_d   = isMul_x;
                    div_d    = ~isMul_x;
                    busy_d   = 6'd0;
                end
            end
            S_START: begin
                state_d = S_BUSY;
                busy_d  = 6'd0;
            end
            S_BUSY: begin
                busy_d = (busy_q == 6'd63) ? busy_q : busy_q + 6'd1;
                // ready takes priority over a coincident timeout
                if (md_resultRDY) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    exc_d   = md_exception;
                    res_d   = md_exception ? exc_code : md_result;
                    reg_d   = md_exception ? RSTATUS_REG : rd_q;
                end else if (busy_q == TO_LAST) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    exc_d   = 1'b1;
                    res_d   = exc_code;
                    reg_d   = RSTATUS_REG;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            is_mul_q <= 1'b0;
            rd_q     <= 5'd0;
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
            mult_q   <= 1'b0;
            div_q    <= 1'b0;
            busy_q   <= 6'd0;
            valid_q  <= 1'b0;
            res_q    <= 32'd0;
            reg_q    <= 5'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_mul_q <= is_mul_d;
            rd_q     <= rd_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            mult_q   <= mult_d;
            div_q    <= div_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            res_q    <= res_d;
            reg_q    <= reg_d;
            exc_q    <= exc_d;
        end
    end

    // stall is combinational in IDLE so the detect cycle itself holds the pipe
    assign isStillMultDiv = (state_q == S_IDLE && op_x)
                          || state_q == S_START
                          || state_q == S_BUSY;

    assign ctrl_MULT        = mult_q;
    assign ctrl_DIV         = div_q;
    assign md_operandA      = opa_q;
    assign md_operandB      = opb_q;
    assign result_valid     = valid_q;
    assign result_out       = res_q;
    assign result_reg       = reg_q;
    assign result_exception = exc_q;
    assign busy_cycles      = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl.
// Drives one op at a time, counts pulses/stall cycles, checks completion.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        isMul_x, isDiv_x;
    logic [4:0]  rd_x;
    logic [31:0] operand_a, operand_b;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] md_operandA, md_operandB;
    logic        isStillMultDiv, result_valid;
    logic [31:0] result_out;
    logic [4:0]  result_reg;
    logic        result_exception;
    logic [5:0]  busy_cycles;

    int pass_cnt = 0;
    int total    = 0;
    int done_at, mults, divs, stalls;

    always #5 clock = ~clock;

    multdiv_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .isMul_x         (isMul_x),
        .isDiv_x         (isDiv_x),
        .rd_x            (rd_x),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .md_result       (md_result),
        .md_exception    (md_exception),
        .md_resultRDY    (md_resultRDY),
        .ctrl_MULT       (ctrl_MULT),
        .ctrl_DIV        (ctrl_DIV),
        .md_operandA     (md_operandA),
        .md_operandB     (md_operandB),
        .isStillMultDiv  (isStillMultDiv),
        .result_valid    (result_valid),
        .result_out      (result_out),
        .result_reg      (result_reg),
        .result_exception(result_exception),
        .busy_cycles     (busy_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents an op in the current (IDLE) cycle, then runs until result_valid.
    // rdy_at is the cycle (relative to detect) in which RDY is driven; -1 = never.
    task automatic do_op(input logic mul, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int rdy_at, input logic [31:0] res,
                         input logic exc);
        int cyc;
        isMul_x = mul;
        isDiv_x = !mul;
        operand_a = a;
        operand_b = b;
        rd_x = rd;
        md_resultRDY = 1'b0;
        #1;
        stalls = int'(isStillMultDiv);
        mults = 0;
        divs = 0;
        done_at = -1;
        cyc = 0;
        while (done_at < 0 && cyc < 100) begin
            tick();
            cyc++;
            isMul_x = 1'b0;
            isDiv_x = 1'b0;
            operand_a = 32'hdead_beef;
            operand_b = 32'h1234_5678;
            rd_x = 5'd31;
            md_resultRDY = (cyc == rdy_at);
            md_result = res;
            md_exception = exc;
            #1;
            mults += int'(ctrl_MULT);
            divs += int'(ctrl_DIV);
            stalls += int'(isStillMultDiv);
            if (result_valid) done_at = cyc;
        end
        md_resultRDY = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        isMul_x = 0;
        isDiv_x = 0;
        rd_x = 0;
        operand_a = 0;
        operand_b = 0;
        md_result = 0;
        md_exception = 0;
        md_resultRDY = 0;
        tick();
        tick();
        chk("rst_valid", result_valid, 0);
        chk("rst_stall", isStillMultDiv, 0);
        chk("rst_mult", ctrl_MULT, 0);
        chk("rst_out", result_out, 0);
        reset = 1'b1;
        tick();

        // mul 7x6, RDY 17 cycles after START
        do_op(1'b1, 32'd7, 32'd6, 5'd3, 18, 32'd42, 1'b0);
        chk("mul_done_at", done_at, 19);
        chk("mul_stalls", stalls, 19);
        chk("mul_pulses", mults, 1);
        chk("mul_divpulses", divs, 0);
        chk("mul_opa", md_operandA, 7);
        chk("mul_opb", md_operandB, 6);
        chk("mul_out", result_out, 42);
        chk("mul_reg", result_reg, 3);
        chk("mul_exc", result_exception, 0);
        chk("mul_busy", busy_cycles, 17);
        tick();
        chk("mul_valid_once", result_valid, 0);
        chk("mul_idle_stall", isStillMultDiv, 0);

        // div 100/0 with exception, minimum latency
        do_op(1'b0, 32'd100, 32'd0, 5'd5, 2, 32'd0, 1'b1);
        chk("div0_done_at", done_at, 3);
        chk("div0_stalls", stalls, 3);
        chk("div0_pulses", divs, 1);
        chk("div0_out", result_out, 5);
        chk("div0_reg", result_reg, 30);
        chk("div0_exc", result_exception, 1);
        tick();

        // mul overflow
        do_op(1'b1, 32'h10000, 32'h10000, 5'd7, 5, 32'd0, 1'b1);
        chk("mulov_done_at", done_at, 6);
        chk("mulov_out", result_out, 4);
        chk("mulov_reg", result_reg, 30);
        chk("mulov_exc", result_exception, 1);
        tick();

        // div timeout
        do_op(1'b0, 32'd9, 32'd3, 5'd6, -1, 32'd0, 1'b0);
        chk("to_done_at", done_at, 42);
        chk("to_stalls", stalls, 42);
        chk("to_out", result_out, 5);
        chk("to_reg", result_reg, 30);
        chk("to_exc", result_exception, 1);
        chk("to_busy", busy_cycles, 40);
        tick();

        // RDY coincident with timeout: RDY wins
        do_op(1'b1, 32'd11, 32'd2, 5'd8, 41, 32'd123, 1'b0);
        chk("tie_done_at", done_at, 42);
        chk("tie_out", result_out, 123);
        chk("tie_reg", result_reg, 8);
        chk("tie_exc", result_exception, 0);
        tick();

        // back-to-back mul then div; retiring mul stays in X during DONE
        do_op(1'b1, 32'd2, 32'd3, 5'd1, 3, 32'd6, 1'b0);
        chk("b2b_mul_pulses", mults, 1);
        chk("b2b_mul_reg", result_reg, 1);
        isMul_x = 1'b1;
        #1;
        chk("b2b_done_stall", isStillMultDiv, 0);
        tick();
        do_op(1'b0, 32'd8, 32'd2, 5'd2, 4, 32'd4, 1'b0);
        chk("b2b_no_reissue", mults, 0);
        chk("b2b_div_pulses", divs, 1);
        chk("b2b_div_reg", result_reg, 2);
        chk("b2b_div_out", result_out, 4);
        tick();

        // reset during BUSY
        isMul_x = 1'b1;
        operand_a = 32'd3;
        operand_b = 32'd4;
        rd_x = 5'd4;
        tick();
        isMul_x = 1'b0;
        tick();
        tick();
        chk("rb_busy_stall", isStillMultDiv, 1);
        reset = 1'b0;
        tick();
        chk("rb_stall", isStillMultDiv, 0);
        chk("rb_mult", ctrl_MULT, 0);
        chk("rb_div", ctrl_DIV, 0);
        chk("rb_valid", result_valid, 0);
        chk("rb_exc", result_exception, 0);
        chk("rb_opa", md_operandA, 0);
        chk("rb_opb", md_operandB, 0);
        chk("rb_out", result_out, 0);
        chk("rb_reg", result_reg, 0);
        chk("rb_busy", busy_cycles, 0);
        reset = 1'b1;
        md_resultRDY = 1'b1;
        md_result = 32'd77;
        tick();
        chk("rb_late_rdy1", result_valid, 0);
        tick();
        chk("rb_late_rdy2", result_valid, 0);
        md_resultRDY = 1'b0;
        isMul_x = 1'b1;
        isDiv_x = 1'b1;
        #1;
        chk("both_stall", isStillMultDiv, 1);
        tick();
        isMul_x = 1'b0;
        isDiv_x = 1'b0;
        #1;
        chk("both_mult", ctrl_MULT, 1);
        chk("both_div", ctrl_DIV, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
